// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Sequencer between the execute stage and the external pipelined signed
//   32x32 multiplier. Issues MULT/MULTU, tracks in-flight products with a
//   valid/unsigned/correction pipeline, writes HI/LO in issue order, serves
//   MTHI/MTLO/MFHI/MFLO and stalls HI/LO ops while products are in flight.
// Ports:
//   clk, rst (sync, active-low)
//   op_valid/op_code/rs_data/rt_data : operation from the CPU
//   stall, rd_data, rd_valid         : combinational responses to the CPU
//   busy                             : any multiply in flight
//   mul_a/mul_b -> Mul, mul_z <- Mul : multiplier interface
//   hi, lo                           : architectural HI/LO registers
module muldiv_hilo_ctrl #(
    parameter int MUL_LATENCY = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4,
        OP_MFHI  = 3'd5,
        OP_MFLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    op_e op;
    assign op = op_e'(op_code);

    logic [MUL_LATENCY-1:0]       vld;
    logic [MUL_LATENCY-1:0]       uns;
    logic [MUL_LATENCY-1:0][31:0] corr;

    logic        hilo_op;
    logic        accept;
    logic        issue;
    logic [31:0] corr_in;
    logic [63:0] wb_val;

    assign busy    = |vld;
    assign hilo_op = (op == OP_MTHI) || (op == OP_MTLO) || (op == OP_MFHI) || (op == OP_MFLO);
    // Gated by rst so the CPU never sees a stall or a read while in reset.
    assign stall   = rst & op_valid & busy & hilo_op;
    assign accept  = rst & op_valid & ~stall;
    assign issue   = accept && ((op == OP_MULT) || (op == OP_MULTU));

    assign mul_a = issue ? rs_data : 32'd0;
    assign mul_b = issue ? rt_data : 32'd0;

    // Signed-to-unsigned product fixup: a negative operand in signed form
    // loses 2^32 * (other operand); adding it back into HI yields the
    // unsigned product modulo 2^64.
    assign corr_in = (rs_data[31] ? rt_data : 32'd0) + (rt_data[31] ? rs_data : 32'd0);

    assign wb_val = mul_z + (uns[MUL_LATENCY-1] ? {corr[MUL_LATENCY-1], 32'd0} : 64'd0);

    assign rd_valid = accept && ((op == OP_MFHI) || (op == OP_MFLO));

    always_comb begin
        rd_data = 32'd0;
        if (op == OP_MFHI)      rd_data = hi;
        else if (op == OP_MFLO) rd_data = lo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            vld  <= '0;
            uns  <= '0;
            corr <= '0;
        end else begin
            vld  <= {vld[MUL_LATENCY-2:0], issue};
            uns  <= {uns[MUL_LATENCY-2:0], issue && (op == OP_MULTU)};
            corr <= {corr[MUL_LATENCY-2:0], issue ? corr_in : 32'd0};
            // MTHI/MTLO only accepted when idle, so they never collide with
            // a writeback.
            if (vld[MUL_LATENCY-1]) begin
                {hi, lo} <= wb_val;
            end else if (accept && op == OP_MTHI) begin
                hi <= rs_data;
            end else if (accept && op == OP_MTLO) begin
                lo <= rs_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_data, rt_data;
    logic        stall, rd_valid, busy;
    logic [31:0] rd_data, mul_a, mul_b, hi, lo;
    logic [63:0] mul_z;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, MTHI = 3'd3,
                           MTLO = 3'd4, MFHI = 3'd5, MFLO = 3'd6, RSVD = 3'd7;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.MUL_LATENCY(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
        .mul_z(mul_z), .hi(hi), .lo(lo)
    );

    // Behavioural 6-register signed multiplier: operands captured at edge k,
    // product on mul_z during cycle k+5.
    logic [63:0] mp [6];
    always @(posedge clk) begin
        mp[0] <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
        for (int i = 1; i < 6; i++) mp[i] <= mp[i-1];
    end
    assign mul_z = mp[5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op_code = c; rs_data = a; rt_data = b;
        #1;
    endtask

    task automatic idle();
        op_valid = 1'b0; op_code = NONE; rs_data = 32'd0; rt_data = 32'd0;
        #1;
    endtask

    // Issue one multiply and wait until its writeback edge has passed.
    task automatic do_mul(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        present(c, a, b);
        tick();
        idle();
        repeat (6) tick();
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 6; i++) mp[i] = 64'd0;
        present(MFHI, 32'd0, 32'd0);
        tick(); tick();
        chk("rst_stall", stall, 1'b0);
        chk("rst_rdvalid", rd_valid, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        idle();
        rst = 1'b1;
        tick();

        // MULT -3 * 5, busy timing
        present(MULT, 32'hFFFF_FFFD, 32'd5);
        chk("drv_mul_a", mul_a, 32'hFFFF_FFFD);
        chk("drv_mul_b", mul_b, 32'd5);
        chk("mult_nostall", stall, 1'b0);
        tick();
        idle();
        chk("idle_mul_a", mul_a, 32'd0);
        chk("busy_k", busy, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("busy_k%0d", i), busy, 1'b1);
        end
        tick();
        chk("busy_k6", busy, 1'b0);
        chk("m3x5_hi", hi, 32'hFFFF_FFFF);
        chk("m3x5_lo", lo, 32'hFFFF_FFF1);

        // MULTU / MULT of all-ones
        do_mul(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_ff_hi", hi, 32'hFFFF_FFFE);
        chk("multu_ff_lo", lo, 32'h0000_0001);
        do_mul(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mult_ff_hi", hi, 32'd0);
        chk("mult_ff_lo", lo, 32'd1);
        // 0x80000000 * 3 unsigned = 0x1_80000000
        do_mul(MULTU, 32'h8000_0000, 32'd3);
        chk("multu_8x3_hi", hi, 32'd1);
        chk("multu_8x3_lo", lo, 32'h8000_0000);

        // MFHI held behind an in-flight MULT
        present(MULT, 32'h7FFF_FFFF, 32'd2);
        tick();
        present(MFHI, 32'd0, 32'd0);
        chk("mfhi_stall_k", stall, 1'b1);
        chk("mfhi_rdv_k", rd_valid, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("mfhi_stall_k%0d", i), stall, 1'b1);
        end
        tick();
        chk("mfhi_stall_k6", stall, 1'b0);
        chk("mfhi_rdv_k6", rd_valid, 1'b1);
        chk("mfhi_data", rd_data, 32'd0);
        tick();
        present(MFLO, 32'd0, 32'd0);
        chk("mflo_rdv", rd_valid, 1'b1);
        chk("mflo_data", rd_data, 32'hFFFF_FFFE);
        tick();

        // Back-to-back issue, MTLO waits for both
        present(MULT, 32'd2, 32'd3);
        tick();
        present(MULT, 32'd7, 32'd11);
        chk("b2b_nostall", stall, 1'b0);
        tick();
        idle();
        tick();
        present(MTLO, 32'h1234, 32'd0);
        chk("mtlo_stall_k2", stall, 1'b1);
        repeat (3) tick();
        chk("mtlo_stall_k5", stall, 1'b1);
        tick();
        chk("b2b_lo_first", lo, 32'd6);
        chk("mtlo_stall_k6", stall, 1'b1);
        tick();
        chk("b2b_lo_second", lo, 32'd77);
        chk("b2b_hi", hi, 32'd0);
        chk("mtlo_stall_k7", stall, 1'b0);
        tick();
        idle();
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi_keep", hi, 32'd0);

        // MTHI then reset mid-flight flushes the pending product
        present(MTHI, 32'hCAFE_0001, 32'd0);
        tick();
        idle();
        chk("mthi_hi", hi, 32'hCAFE_0001);
        present(MULT, 32'd9, 32'd9);
        tick();
        idle();
        tick(); tick();
        rst = 1'b0;
        present(MFHI, 32'd0, 32'd0);
        chk("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_rdv", rd_valid, 1'b0);
        tick();
        rst = 1'b1;
        idle();
        chk("flush_busy", busy, 1'b0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'd0);
        repeat (5) tick();
        chk("flush_nowb_hi", hi, 32'd0);
        chk("flush_nowb_lo", lo, 32'd0);

        // Reserved opcode has no effect
        present(MTLO, 32'h5555_AAAA, 32'd0);
        tick();
        present(RSVD, 32'h1111_2222, 32'h3333_4444);
        chk("rsvd_stall", stall, 1'b0);
        chk("rsvd_rdv", rd_valid, 1'b0);
        chk("rsvd_mul_a", mul_a, 32'd0);
        tick();
        idle();
        chk("rsvd_busy", busy, 1'b0);
        chk("rsvd_hi", hi, 32'd0);
        chk("rsvd_lo", lo, 32'h5555_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
